axis_tg_lfsr: RTL and testbench
===============================

Name: axis_tg_lfsr

Overview:
Synthesizable AXI-Stream traffic generator. It is the transmit end paired with axis_checker, for on-FPGA mesh characterisation where the simulation-only generator cannot be used.
- Open-loop injection of single-flit packets at a programmable load, using LFSR-based Bernoulli trials.
- Pseudo-random destinations; each flit carries a timestamp and a per-destination sequence number so that axis_checker can measure latency and detect errors.
- One instance per mesh endpoint, in the user clock domain, driving axis_mesh axis_in_*.

Parameters:
SEED, 1, LFSR seed; 0 is mapped to 1; the destination LFSR uses SEED ^ 16'hACE1, also mapped to 1 if 0
COUNT_WIDTH, 32, width of packet counters and num_packets
TID, 0, constant value driven on axis_out_tid (source id)
TDATA_WIDTH, 64, flit width; must be even and at least 2*COUNT_WIDTH/2
TDEST_WIDTH, 2, destination width; must be at least clog2(NUM_ROUTERS)
TID_WIDTH, 2, source id width
NUM_ROUTERS, 4, number of valid destinations, 0..NUM_ROUTERS-1
BACKLOG_WIDTH, 16, width of the source-queue occupancy counter

Ports:
clk  in  1  user clock
rst_n  in  1  asynchronous active-low reset
load  in  16  injection probability = load/65535; sampled every cycle
num_packets  in  COUNT_WIDTH  packets to generate per run
start  in  1  level; rising use starts a run
ticks  in  TDATA_WIDTH/2  free-running timestamp
done  out  1  run complete and drained
sent_packets  out  [NUM_ROUTERS][COUNT_WIDTH]  handshaken packets per destination
total_sent_packets  out  COUNT_WIDTH  handshaken packets, all destinations
axis_out_tvalid  out  1  AXIS valid
axis_out_tready  in  1  AXIS ready
axis_out_tdata  out  TDATA_WIDTH  {ticks at load, zero-pad, per-dest seq number}
axis_out_tlast  out  1  always 1 while tvalid
axis_out_tdest  out  TDEST_WIDTH  destination
axis_out_tid  out  TID_WIDTH  constant TID

Behaviour:
- Reset (async, rst_n=0):
  - All state and counters are cleared and the FSM goes to IDLE.
  - tvalid, done, tdata, tdest, the counters and tlast are all 0.
  - tid = TID.
  - Both LFSRs are reloaded with their seeds.
  - Asserting reset mid-run aborts immediately and drops the in-flight flit.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN when start=1. On entry, gen_count, backlog and all sent counters are cleared.
  - RUN -> DRAIN in the cycle after gen_count reaches num_packets. If num_packets=0, the FSM goes RUN -> DRAIN after one cycle with zero injections.
  - DRAIN -> DONE when backlog==0 and tvalid==0.
  - DONE: done=1. DONE -> IDLE when start=0. Counters hold their values in DONE and IDLE until the next run.
  - Deasserting start during RUN or DRAIN is ignored.
- Injection, in RUN only:
  - The 16-bit maximal Galois LFSR (taps x^16+x^14+x^13+x^11+1) advances every cycle in all states. Its value range is 1..65535.
  - Inject decision = (lfsr <= load) && gen_count < num_packets && backlog != all-ones.
  - load=0 never injects; load=16'hFFFF injects every cycle.
  - A decision increments gen_count and backlog. A decision suppressed by a full backlog is not counted.
- Output register:
  - Loads when backlog>0 and (!tvalid || tready). Backlog decrements on load.
  - A simultaneous increment and decrement leaves backlog unchanged.
  - Latency: decision in cycle N -> backlog nonzero at N+1 -> tvalid at N+2 (minimum).
  - Loaded fields:
    - tdest = dest LFSR low TDEST_WIDTH bits, minus NUM_ROUTERS if >= NUM_ROUTERS.
    - tdata upper half = ticks.
    - tdata low COUNT_WIDTH/2 bits = seq[tdest].
    - seq[tdest] increments on load.
  - The dest LFSR advances only on load.
- AXIS rules:
  - tvalid is held with stable payload until tready.
  - tvalid never depends combinationally on tready.
  - Back-to-back flits are emitted with tready held at 1.
- Handshake (tvalid && tready): increments sent_packets[tdest] and total_sent_packets. Counters wrap at 2^COUNT_WIDTH.

Decomposition:
- Package axis_tg_pkg:
  - state_t enum.
  - LFSR polynomial constants.
  - The TDATA field-offset localparams shared with axis_checker (timestamp high half, seq low COUNT_WIDTH/2 bits).
- Sub-module lfsr16: seed parameter, enable, value output, async reset. Instantiated twice (injection and destination).

Test Plan:
- load=16'hFFFF, num_packets=8, tready=1 -> 8 flits on consecutive cycles, first tvalid 2 cycles after RUN entry; total_sent_packets=8; done=1 after drain; sum of sent_packets[*]=8.
- load=0, num_packets=4 -> no tvalid ever, done never asserts; then reset -> all outputs 0.
- load=16'hFFFF, num_packets=16, tready held 0 for 20 cycles then 1 -> tvalid/payload stable while stalled, backlog=15 after generation, all 16 delivered, seq per dest contiguous from 0.
- num_packets=0, start=1 -> done=1 within 3 cycles with no flit; start=0 -> done falls next cycle (IDLE).
- load=16'h8000, num_packets=4096, random tready -> accepted rate 0.5 +/- 0.03; tdest always < NUM_ROUTERS; axis_checker error=0.
- rst_n pulsed low mid-stall with tvalid=1 -> tvalid falls asynchronously, counters 0, fresh run repeats identical LFSR sequence.

Source files
------------

// File: rtl/axis_tg_pkg.sv
// Shared definitions for the LFSR-driven AXI-Stream traffic generator and its checker:
// FSM encoding, LFSR polynomial and the TDATA field layout.
package axis_tg_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_t;

  // Galois form of x^16 + x^14 + x^13 + x^11 + 1, right-shifting.
  localparam logic [15:0] LfsrTaps    = 16'hB400;
  localparam logic [15:0] DestSeedXor = 16'hACE1;

  // Sequence number sits at the bottom of TDATA; the timestamp fills the upper half.
  localparam int unsigned SeqLsb = 0;

  function automatic int unsigned ts_lsb(int unsigned tdata_width);
    return tdata_width / 2;
  endfunction

  function automatic int unsigned seq_width(int unsigned count_width);
    return count_width / 2;
  endfunction

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  function automatic logic [15:0] lfsr_seed(logic [15:0] seed);
    return (seed == 16'h0000) ? 16'h0001 : seed;
  endfunction

  function automatic logic [15:0] lfsr_next(logic [15:0] value);
    return {1'b0, value[15:1]} ^ (value[0] ? LfsrTaps : 16'h0000);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit maximal-length Galois LFSR with enable; reset reloads the (non-zero) seed.
module lfsr16
  import axis_tg_pkg::*;
#(
  parameter logic [15:0] SEED = 16'h0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] value
);

  localparam logic [15:0] SeedFixed = lfsr_seed(SEED);

  logic [15:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (en) value_d = lfsr_next(value_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= SeedFixed;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/axis_tg_lfsr.sv
// Open-loop AXI-Stream traffic generator: Bernoulli injection of single-flit packets into a
// source backlog, drained through a registered AXIS output with per-destination sequence numbers.
module axis_tg_lfsr
  import axis_tg_pkg::*;
#(
  parameter logic [15:0] SEED          = 16'd1,
  parameter int unsigned COUNT_WIDTH   = 32,
  parameter int unsigned TID           = 0,
  parameter int unsigned TDATA_WIDTH   = 64,
  parameter int unsigned TDEST_WIDTH   = 2,
  parameter int unsigned TID_WIDTH     = 2,
  parameter int unsigned NUM_ROUTERS   = 4,
  parameter int unsigned BACKLOG_WIDTH = 16
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [15:0]                             load,
  input  logic [COUNT_WIDTH-1:0]                  num_packets,
  input  logic                                    start,
  input  logic [TDATA_WIDTH/2-1:0]                ticks,
  output logic                                    done,
  output logic [NUM_ROUTERS-1:0][COUNT_WIDTH-1:0] sent_packets,
  output logic [COUNT_WIDTH-1:0]                  total_sent_packets,
  output logic                                    axis_out_tvalid,
  input  logic                                    axis_out_tready,
  output logic [TDATA_WIDTH-1:0]                  axis_out_tdata,
  output logic                                    axis_out_tlast,
  output logic [TDEST_WIDTH-1:0]                  axis_out_tdest,
  output logic [TID_WIDTH-1:0]                    axis_out_tid
);

  localparam int unsigned TsLsb = ts_lsb(TDATA_WIDTH);
  localparam int unsigned TsW   = TDATA_WIDTH - TsLsb;
  localparam int unsigned SeqW  = seq_width(COUNT_WIDTH);
  localparam logic [TDEST_WIDTH:0] NumDest = (TDEST_WIDTH + 1)'(NUM_ROUTERS);

  state_t                                 state_q, state_d;
  logic [COUNT_WIDTH-1:0]                 gen_count_q, gen_count_d;
  logic [BACKLOG_WIDTH-1:0]               backlog_q, backlog_d;
  logic [NUM_ROUTERS-1:0][SeqW-1:0]       seq_q, seq_d;
  logic [NUM_ROUTERS-1:0][COUNT_WIDTH-1:0] sent_q, sent_d;
  logic [COUNT_WIDTH-1:0]                 total_q, total_d;
  logic                                   tvalid_q, tvalid_d;
  logic [TDATA_WIDTH-1:0]                 tdata_q, tdata_d;
  logic [TDEST_WIDTH-1:0]                 tdest_q, tdest_d;

  logic [15:0]            inj_lfsr;
  logic [15:0]            dest_lfsr;
  logic [TDEST_WIDTH-1:0] dest_raw;
  logic [TDEST_WIDTH-1:0] dest_map;
  logic                   inject;
  logic                   out_load;
  logic                   handshake;
  logic                   unused_dest_hi;

  lfsr16 #(
    .SEED (SEED)
  ) u_inj_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .value (inj_lfsr)
  );

  // The destination stream only advances when a flit is actually emitted.
  lfsr16 #(
    .SEED (SEED ^ DestSeedXor)
  ) u_dest_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (out_load),
    .value (dest_lfsr)
  );

  assign unused_dest_hi = ^dest_lfsr[15:TDEST_WIDTH];

  always_comb begin
    dest_raw = dest_lfsr[TDEST_WIDTH-1:0];
    dest_map = dest_raw;
    if ({1'b0, dest_raw} >= NumDest) dest_map = dest_raw - NumDest[TDEST_WIDTH-1:0];
  end

  assign handshake = tvalid_q && axis_out_tready;
  assign out_load  = (backlog_q != '0) && (!tvalid_q || axis_out_tready);
  assign inject    = (state_q == StRun) && (inj_lfsr <= load) &&
                     (gen_count_q < num_packets) && (backlog_q != '1);

  always_comb begin
    state_d     = state_q;
    gen_count_d = gen_count_q;
    backlog_d   = backlog_q;
    seq_d       = seq_q;
    sent_d      = sent_q;
    total_d     = total_q;
    tvalid_d    = tvalid_q;
    tdata_d     = tdata_q;
    tdest_d     = tdest_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StRun;
          gen_count_d = '0;
          backlog_d   = '0;
          seq_d       = '0;
          sent_d      = '0;
          total_d     = '0;
        end
      end
      StRun: begin
        if (gen_count_q >= num_packets) state_d = StDrain;
      end
      StDrain: begin
        if ((backlog_q == '0) && !tvalid_q) state_d = StDone;
      end
      StDone: begin
        if (!start) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (inject) gen_count_d = gen_count_q + COUNT_WIDTH'(1);

    if (inject && !out_load) begin
      backlog_d = backlog_q + BACKLOG_WIDTH'(1);
    end else if (!inject && out_load) begin
      backlog_d = backlog_q - BACKLOG_WIDTH'(1);
    end

    if (out_load) begin
      tvalid_d                   = 1'b1;
      tdest_d                    = dest_map;
      tdata_d                    = '0;
      tdata_d[TsLsb +: TsW]      = ticks;
      tdata_d[SeqLsb +: SeqW]    = seq_q[dest_map];
      seq_d[dest_map]            = seq_q[dest_map] + SeqW'(1);
    end else if (axis_out_tready) begin
      tvalid_d = 1'b0;
    end

    if (handshake) begin
      sent_d[tdest_q] = sent_q[tdest_q] + COUNT_WIDTH'(1);
      total_d         = total_q + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      gen_count_q <= '0;
      backlog_q   <= '0;
      seq_q       <= '0;
      sent_q      <= '0;
      total_q     <= '0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tdest_q     <= '0;
    end else begin
      state_q     <= state_d;
      gen_count_q <= gen_count_d;
      backlog_q   <= backlog_d;
      seq_q       <= seq_d;
      sent_q      <= sent_d;
      total_q     <= total_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      tdest_q     <= tdest_d;
    end
  end

  assign done               = (state_q == StDone);
  assign sent_packets       = sent_q;
  assign total_sent_packets = total_q;
  assign axis_out_tvalid    = tvalid_q;
  assign axis_out_tdata     = tdata_q;
  assign axis_out_tlast     = tvalid_q;
  assign axis_out_tdest     = tdest_q;
  assign axis_out_tid       = TID_WIDTH'(TID);

endmodule

// File: tb/tb_axis_tg_lfsr.sv
// Scoreboard bench for axis_tg_lfsr: stimulus pushes expected flits, a monitor pops and
// compares on every handshake and also checks payload stability while stalled.
module tb_axis_tg_lfsr;

  localparam int unsigned CW   = 32;
  localparam int unsigned TDW  = 64;
  localparam int unsigned DW   = 2;
  localparam int unsigned IW   = 2;
  localparam int unsigned NR   = 4;
  localparam int unsigned TIDV = 0;

  logic                     clk         = 1'b0;
  logic                     rst_n       = 1'b0;
  logic [15:0]              load        = 16'h0;
  logic [CW-1:0]            num_packets = '0;
  logic                     start       = 1'b0;
  logic [TDW/2-1:0]         ticks       = '0;
  logic                     tready      = 1'b1;
  logic                     done;
  logic [NR-1:0][CW-1:0]    sent_packets;
  logic [CW-1:0]            total_sent_packets;
  logic                     tvalid;
  logic [TDW-1:0]           tdata;
  logic                     tlast;
  logic [DW-1:0]            tdest;
  logic [IW-1:0]            tid;

  axis_tg_lfsr #(
    .SEED          (16'd1),
    .COUNT_WIDTH   (CW),
    .TID           (TIDV),
    .TDATA_WIDTH   (TDW),
    .TDEST_WIDTH   (DW),
    .TID_WIDTH     (IW),
    .NUM_ROUTERS   (NR),
    .BACKLOG_WIDTH (16)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .load               (load),
    .num_packets        (num_packets),
    .start              (start),
    .ticks              (ticks),
    .done               (done),
    .sent_packets       (sent_packets),
    .total_sent_packets (total_sent_packets),
    .axis_out_tvalid    (tvalid),
    .axis_out_tready    (tready),
    .axis_out_tdata     (tdata),
    .axis_out_tlast     (tlast),
    .axis_out_tdest     (tdest),
    .axis_out_tid       (tid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ticks <= ticks + 32'd1;

  // Destination stream from seed 1 ^ 16'hACE1 = 16'hACE0, low two bits per step.
  int dest_tab [16] = '{0, 0, 0, 0, 2, 3, 3, 1, 0, 2, 3, 1, 2, 1, 2, 3};

  typedef struct {
    int unsigned mode;   // 0: exact dest/seq/timestamp, 1: dest range and per-dest seq order
    bit          first;
    logic [1:0]  dest;
    logic [15:0] seq;
    logic [31:0] ts;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
  endtask

  task automatic check_sent(input string tag, input int unsigned e0, input int unsigned e1,
                            input int unsigned e2, input int unsigned e3);
    int unsigned ex [4];
    ex = '{e0, e1, e2, e3};
    for (int i = 0; i < NR; i++) begin
      check($sformatf("%s_sent%0d", tag, i), 64'(sent_packets[i]), 64'(ex[i]));
    end
  endtask

  // t_rdy == 0 means tready stays high; otherwise tready rises in cycle t_rdy after a stall.
  task automatic push_directed(input int n, input logic [31:0] c0, input logic [31:0] t_rdy);
    int   cnt [NR];
    exp_t e;
    for (int i = 0; i < NR; i++) cnt[i] = 0;
    for (int k = 0; k < n; k++) begin
      e.mode  = 0;
      e.first = (k == 0);
      e.dest  = 2'(dest_tab[k]);
      e.seq   = 16'(cnt[dest_tab[k]]);
      cnt[dest_tab[k]]++;
      if (t_rdy == 32'd0 || k == 0) e.ts = c0 + 32'd2 + 32'(k);
      else e.ts = t_rdy + 32'(k) - 32'd1;
      sb_q.push_back(e);
    end
  endtask

  // Monitor
  int          mon_seq [NR];
  logic        stall_q = 1'b0;
  logic [TDW-1:0] prev_data;
  logic [DW-1:0]  prev_dest;
  exp_t        mon_e;

  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("stall_hold_tvalid", 64'(tvalid), 64'd1);
        check("stall_hold_tdata", tdata, prev_data);
        check("stall_hold_tdest", 64'(tdest), 64'(prev_dest));
      end
      if (tvalid && tready) begin
        check("flit_tlast", 64'(tlast), 64'd1);
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_flit: got dest %0d data 0x%0h, expected no flit", tdest, tdata);
        end else begin
          mon_e = sb_q.pop_front();
          if (mon_e.first) for (int i = 0; i < NR; i++) mon_seq[i] = 0;
          if (mon_e.mode == 0) begin
            check("flit_tdest", 64'(tdest), 64'(mon_e.dest));
            check("flit_seq", 64'(tdata[15:0]), 64'(mon_e.seq));
            check("flit_pad", 64'(tdata[31:16]), 64'd0);
            check("flit_ts", 64'(tdata[63:32]), 64'(mon_e.ts));
          end else begin
            check("flit_dest_range", 64'(tdest < NR), 64'd1);
            check("flit_seq_contig", 64'(tdata[15:0]), 64'(mon_seq[tdest]));
            mon_seq[tdest]++;
          end
        end
      end
      stall_q   = tvalid && !tready;
      prev_data = tdata;
      prev_dest = tdest;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; tready = 1'b1; load = 16'h0; num_packets = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input int bound, input string tag);
    int i = 0;
    while (!done && i < bound) begin
      @(negedge clk);
      i++;
    end
    check({tag, "_done"}, 64'(done), 64'd1);
  endtask

  task automatic run_burst8(input string tag);
    logic [31:0] c0;
    @(negedge clk);
    c0 = ticks; load = 16'hFFFF; num_packets = 32'd8; tready = 1'b1; start = 1'b1;
    push_directed(8, c0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check({tag, "_tvalid_c2"}, 64'(tvalid), 64'd0);
    @(negedge clk);
    check({tag, "_tvalid_c3"}, 64'(tvalid), 64'd1);
    wait_done(40, tag);
    check({tag, "_total"}, 64'(total_sent_packets), 64'd8);
    check_sent(tag, 4, 1, 1, 2);
    check({tag, "_sb_drained"}, 64'(sb_q.size()), 64'd0);
    start = 1'b0;
    @(negedge clk);
    check({tag, "_done_falls"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic [31:0] c0;
    logic [31:0] cyc;
    logic        saw_valid;
    logic        saw_done;
    int          i;
    exp_t        e;

    // Full load, back-to-back burst
    do_reset();
    run_burst8("burst");

    // Stalled sink: backlog builds to 15, payload held, then all 16 drain in order
    do_reset();
    @(negedge clk);
    c0 = ticks; load = 16'hFFFF; num_packets = 32'd16; tready = 1'b0; start = 1'b1;
    push_directed(16, c0, c0 + 32'd21);
    repeat (20) @(negedge clk);
    check("stall_backlog", 64'(dut.backlog_q), 64'd15);
    check("stall_tvalid", 64'(tvalid), 64'd1);
    check("stall_not_done", 64'(done), 64'd0);
    @(negedge clk);
    tready = 1'b1;
    wait_done(60, "stall");
    check("stall_total", 64'(total_sent_packets), 64'd16);
    check_sent("stall", 5, 3, 4, 4);
    check("stall_sb_drained", 64'(sb_q.size()), 64'd0);
    start = 1'b0;
    @(negedge clk);

    // Zero load never injects and never completes; reset then clears everything
    do_reset();
    @(negedge clk);
    load = 16'h0; num_packets = 32'd4; tready = 1'b1; start = 1'b1;
    saw_valid = 1'b0; saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      saw_valid |= tvalid;
      saw_done  |= done;
    end
    check("load0_no_tvalid", 64'(saw_valid), 64'd0);
    check("load0_no_done", 64'(saw_done), 64'd0);
    check("load0_total", 64'(total_sent_packets), 64'd0);
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0;
    #1;
    check("rst_tvalid", 64'(tvalid), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_tdata", tdata, 64'd0);
    check("rst_tdest", 64'(tdest), 64'd0);
    check("rst_tlast", 64'(tlast), 64'd0);
    check("rst_total", 64'(total_sent_packets), 64'd0);
    check_sent("rst", 0, 0, 0, 0);
    check("rst_tid", 64'(tid), 64'(TIDV));
    @(negedge clk);
    rst_n = 1'b1;

    // num_packets = 0 completes without a flit
    do_reset();
    @(negedge clk);
    load = 16'hFFFF; num_packets = '0; tready = 1'b1; start = 1'b1;
    saw_valid = 1'b0; i = 0;
    while (!done && i < 3) begin
      @(negedge clk);
      saw_valid |= tvalid;
      i++;
    end
    check("zero_done_3cyc", 64'(done), 64'd1);
    check("zero_no_flit", 64'(saw_valid), 64'd0);
    check("zero_total", 64'(total_sent_packets), 64'd0);
    start = 1'b0;
    @(negedge clk);
    check("zero_done_falls", 64'(done), 64'd0);

    // Half load with a random sink: ~2 cycles per packet, destinations in range
    do_reset();
    @(negedge clk);
    c0 = ticks; load = 16'h8000; num_packets = 32'd4096; tready = 1'b1; start = 1'b1;
    for (int k = 0; k < 4096; k++) begin
      e.mode = 1; e.first = (k == 0); e.dest = '0; e.seq = '0; e.ts = '0;
      sb_q.push_back(e);
    end
    i = 0;
    while (!done && i < 20000) begin
      @(negedge clk);
      tready = ($urandom_range(3) != 0);
      i++;
    end
    check("rate_done", 64'(done), 64'd1);
    cyc = ticks - c0;
    check("rate_band", 64'((cyc >= 32'd7728) && (cyc <= 32'd8715)), 64'd1);
    check("rate_total", 64'(total_sent_packets), 64'd4096);
    check("rate_sb_drained", 64'(sb_q.size()), 64'd0);
    tready = 1'b1; start = 1'b0;
    @(negedge clk);

    // Reset mid-stall drops the flit; the next run repeats the same destination stream
    do_reset();
    @(negedge clk);
    load = 16'hFFFF; num_packets = 32'd16; tready = 1'b0; start = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_pre_tvalid", 64'(tvalid), 64'd1);
    #2;
    rst_n = 1'b0; start = 1'b0;
    #1;
    check("abort_tvalid_async", 64'(tvalid), 64'd0);
    check("abort_tdata", tdata, 64'd0);
    check("abort_backlog", 64'(dut.backlog_q), 64'd0);
    check("abort_total", 64'(total_sent_packets), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_burst8("rerun");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
